// File: rtl/simon_pkg.sv
// Shared types for the Simon Says round sequencer: FSM states, colour codes
// and the one-hot button to colour-code conversion.
package simon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHOW_ON,
        ST_SHOW_GAP,
        ST_INPUT,
        ST_FAIL,
        ST_WIN
    } round_state_t;

    typedef logic [1:0] colour_t;

    localparam int MAX_ROUND_DEFAULT = 32;

    // Multi-hot inputs map to their highest set bit; callers gate on onehot.
    function automatic colour_t onehot_to_code(input logic [3:0] oh);
        colour_t code;
        code = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) begin
                code = colour_t'(i);
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/press_detect.sv
// Button edge detector: press pulses in the cycle buttons leave the all-released
// state; onehot/code describe the buttons sampled in that same cycle.
module press_detect
    import simon_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] btn_i,
    output logic       press_o,
    output logic       onehot_o,
    output colour_t    code_o
);

    logic [3:0] prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= 4'b0000;
        end else begin
            prev_q <= btn_i;
        end
    end

    assign press_o  = (btn_i != 4'b0000) && (prev_q == 4'b0000);
    assign onehot_o = (btn_i != 4'b0000) && ((btn_i & (btn_i - 4'd1)) == 4'b0000);
    assign code_o   = onehot_to_code(btn_i);

endmodule

// File: rtl/simon_round_ctrl.sv
// Simon Says round sequencer: plays back the pattern for the current round,
// then checks the player's presses; all outputs are registered state.
module simon_round_ctrl
    import simon_pkg::*;
#(
    parameter int FLASH_TICKS   = 4,
    parameter int GAP_TICKS     = 2,
    parameter int TIMEOUT_TICKS = 64,
    parameter int MAX_ROUND     = MAX_ROUND_DEFAULT
) (
    input  logic             flash_clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0][2:0] segment,
    input  logic [3:0]       player_input,
    output logic [4:0]       check_round,
    output logic [4:0]       disp_idx,
    output logic             disp_on,
    output logic             expect_input,
    output logic             game_over,
    output logic             win,
    output logic [5:0]       score
);

    localparam int TMAX = (TIMEOUT_TICKS > FLASH_TICKS)
                        ? ((TIMEOUT_TICKS > GAP_TICKS) ? TIMEOUT_TICKS : GAP_TICKS)
                        : ((FLASH_TICKS > GAP_TICKS) ? FLASH_TICKS : GAP_TICKS);
    localparam int TW = $clog2(TMAX) + 1;

    round_state_t state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [4:0]    round_q, round_d;
    logic [4:0]    idx_q, idx_d;
    logic [5:0]    score_q, score_d;

    logic    press;
    logic    onehot;
    colour_t code;
    logic    match;
    logic    unused_seg_bits;

    press_detect u_press (
        .clk_i    (flash_clk),
        .rst_i    (reset),
        .btn_i    (player_input),
        .press_o  (press),
        .onehot_o (onehot),
        .code_o   (code)
    );

    assign match = onehot && (code == segment[idx_q][1:0]);

    // Only the low two bits of each pattern entry carry a colour.
    always_comb begin
        unused_seg_bits = 1'b0;
        for (int i = 0; i < 32; i++) begin
            unused_seg_bits = unused_seg_bits ^ segment[i][2];
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 1'b1;
        round_d = round_q;
        idx_d   = idx_q;
        score_d = score_q;
        case (state_q)
            ST_IDLE, ST_FAIL, ST_WIN: begin
                timer_d = timer_q;
                if (start) begin
                    state_d = ST_SHOW_ON;
                    timer_d = '0;
                    round_d = 5'd0;
                    idx_d   = 5'd0;
                    score_d = 6'd0;
                end
            end
            ST_SHOW_ON: begin
                if (timer_q == TW'(FLASH_TICKS - 1)) begin
                    state_d = ST_SHOW_GAP;
                    timer_d = '0;
                end
            end
            ST_SHOW_GAP: begin
                if (timer_q == TW'(GAP_TICKS - 1)) begin
                    timer_d = '0;
                    if (idx_q < round_q) begin
                        state_d = ST_SHOW_ON;
                        idx_d   = idx_q + 5'd1;
                    end else begin
                        state_d = ST_INPUT;
                        idx_d   = 5'd0;
                    end
                end
            end
            ST_INPUT: begin
                // A press in the timeout cycle is judged, not timed out.
                if (press) begin
                    timer_d = '0;
                    if (!match) begin
                        state_d = ST_FAIL;
                    end else if (idx_q < round_q) begin
                        idx_d = idx_q + 5'd1;
                    end else begin
                        if (score_q < 6'(MAX_ROUND)) begin
                            score_d = score_q + 6'd1;
                        end
                        if (round_q == 5'(MAX_ROUND - 1)) begin
                            state_d = ST_WIN;
                        end else begin
                            state_d = ST_SHOW_ON;
                            round_d = round_q + 5'd1;
                            idx_d   = 5'd0;
                        end
                    end
                end else if (timer_q == TW'(TIMEOUT_TICKS - 1)) begin
                    state_d = ST_FAIL;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge flash_clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            round_q <= 5'd0;
            idx_q   <= 5'd0;
            score_q <= 6'd0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            round_q <= round_d;
            idx_q   <= idx_d;
            score_q <= score_d;
        end
    end

    assign check_round  = round_q;
    assign disp_idx     = idx_q;
    assign disp_on      = (state_q == ST_SHOW_ON);
    assign expect_input = (state_q == ST_INPUT);
    assign game_over    = (state_q == ST_FAIL);
    assign win          = (state_q == ST_WIN);
    assign score        = score_q;

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Game-level bench: drives whole rounds (playback, waits, presses) and checks the
// outputs against expectations derived from the game rules each cycle.
module tb_simon_round_ctrl;

    localparam int FT = 2;
    localparam int GT = 1;
    localparam int TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             start;
    logic [31:0][2:0] segment;
    logic [3:0]       player_input;

    logic [4:0] cr1, di1, cr2, di2;
    logic       don1, exi1, go1, win1, don2, exi2, go2, win2;
    logic [5:0] sc1, sc2;

    simon_round_ctrl #(.FLASH_TICKS(FT), .GAP_TICKS(GT), .TIMEOUT_TICKS(TO), .MAX_ROUND(32)) u_dut (
        .flash_clk(clk), .reset(reset), .start(start), .segment(segment),
        .player_input(player_input), .check_round(cr1), .disp_idx(di1), .disp_on(don1),
        .expect_input(exi1), .game_over(go1), .win(win1), .score(sc1)
    );

    simon_round_ctrl #(.FLASH_TICKS(FT), .GAP_TICKS(GT), .TIMEOUT_TICKS(TO), .MAX_ROUND(2)) u_dut2 (
        .flash_clk(clk), .reset(reset), .start(start), .segment(segment),
        .player_input(player_input), .check_round(cr2), .disp_idx(di2), .disp_on(don2),
        .expect_input(exi2), .game_over(go2), .win(win2), .score(sc2)
    );

    // sel picks which instance is being scored; mr is that instance's round limit.
    logic sel;
    int   mr;
    logic [4:0] o_cr, o_di;
    logic       o_don, o_exi, o_go, o_win;
    logic [5:0] o_sc;
    assign o_cr  = sel ? cr2  : cr1;
    assign o_di  = sel ? di2  : di1;
    assign o_don = sel ? don2 : don1;
    assign o_exi = sel ? exi2 : exi1;
    assign o_go  = sel ? go2  : go1;
    assign o_win = sel ? win2 : win1;
    assign o_sc  = sel ? sc2  : sc1;

    int m_round, m_idx, m_score;
    bit m_go, m_win;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic expect_now(input string where, input logic don, input logic exi);
        check_eq({where, ".check_round"},  32'(o_cr),  32'(m_round));
        check_eq({where, ".disp_idx"},     32'(o_di),  32'(m_idx));
        check_eq({where, ".disp_on"},      32'(o_don), 32'(don));
        check_eq({where, ".expect_input"}, 32'(o_exi), 32'(exi));
        check_eq({where, ".game_over"},    32'(o_go),  32'(m_go));
        check_eq({where, ".win"},          32'(o_win), 32'(m_win));
        check_eq({where, ".score"},        32'(o_sc),  32'(m_score));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        player_input = 4'b0000;
        tick();
        m_round = 0; m_idx = 0; m_score = 0; m_go = 0; m_win = 0;
        expect_now("reset", 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_round = 0; m_idx = 0; m_score = 0; m_go = 0; m_win = 0;
    endtask

    // Playback of round r: entry i lit FT cycles then dark GT cycles; stray start pulses ignored.
    task automatic playback(input logic [3:0] btn);
        player_input = btn;
        for (int i = 0; i <= m_round; i++) begin
            m_idx = i;
            for (int f = 0; f < FT; f++) begin
                expect_now("show_on", 1'b1, 1'b0);
                start = 1'($urandom_range(0, 1));
                tick();
            end
            for (int g = 0; g < GT; g++) begin
                expect_now("show_gap", 1'b0, 1'b0);
                start = 1'($urandom_range(0, 1));
                tick();
            end
        end
        start = 1'b0;
        m_idx = 0;
        expect_now("input_entry", 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        player_input = 4'b0000;
        repeat (n) begin
            tick();
            expect_now("wait", 1'b0, 1'b1);
        end
    endtask

    task automatic hold(input logic [3:0] btn, input int n);
        player_input = btn;
        repeat (n) begin
            tick();
            expect_now("hold", 1'b0, 1'b1);
        end
    endtask

    task automatic press(input logic [3:0] b);
        logic [3:0] want;
        want = 4'b0001 << segment[m_idx][1:0];
        player_input = b;
        tick();
        player_input = 4'b0000;
        if (b != want) begin
            m_go = 1;
            expect_now("press_bad", 1'b0, 1'b0);
        end else if (m_idx < m_round) begin
            m_idx++;
            expect_now("press_next", 1'b0, 1'b1);
        end else begin
            m_score++;
            if (m_round == mr - 1) begin
                m_win = 1;
                expect_now("press_win", 1'b0, 1'b0);
            end else begin
                m_round++;
                m_idx = 0;
                expect_now("press_round", 1'b1, 1'b0);
            end
        end
    endtask

    task automatic correct_step(input int i);
        idle((i == 0) ? $urandom_range(0, TO - 1) : $urandom_range(1, TO - 1));
        press(4'b0001 << segment[m_idx][1:0]);
    endtask

    task automatic play_round();
        int r;
        r = m_round;
        for (int i = 0; i <= r; i++) begin
            correct_step(i);
        end
    endtask

    task automatic timeout_fail();
        idle(TO - 1);
        tick();
        m_go = 1;
        expect_now("timeout", 1'b0, 1'b0);
    endtask

    task automatic frozen(input int n);
        repeat (n) begin
            player_input = 4'($urandom_range(0, 15));
            tick();
            expect_now("frozen", 1'b0, 1'b0);
        end
        player_input = 4'b0000;
    endtask

    initial begin
        int k, j, kind;
        logic [1:0] c;
        logic [3:0] b;

        sel = 1'b0;
        mr  = 32;
        reset = 1'b1;
        start = 1'b0;
        player_input = 4'b0000;
        for (int i = 0; i < 32; i++) segment[i] = 3'(i % 4);
        tick();
        do_reset();

        // First game: round 0 and round 1 shown, then a wrong colour.
        do_start();
        playback(4'b0000);
        press(4'b0001);
        playback(4'b0000);
        press(4'b0001);
        idle(1);
        press(4'b0100);
        frozen(3);

        // Restart from FAIL, then let the input window expire.
        do_start();
        playback(4'b0000);
        timeout_fail();

        // Button held across the INPUT entry is not a press; a multi-hot press fails.
        do_start();
        playback(4'b0001);
        hold(4'b0001, 3);
        idle(1);
        press(4'b0001);
        playback(4'b0000);
        idle(TO - 1);
        press(4'b0001);
        idle(1);
        press(4'b0011);
        frozen(2);

        // Random games on random patterns with random endings.
        for (int g = 0; g < 8; g++) begin
            for (int i = 0; i < 32; i++) segment[i] = 3'($urandom_range(0, 7));
            do_start();
            playback(4'b0000);
            k = $urandom_range(0, 4);
            repeat (k) begin
                play_round();
                playback(4'b0000);
            end
            j = $urandom_range(0, m_round);
            for (int i = 0; i < j; i++) correct_step(i);
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                idle((j == 0) ? 0 : 1);
                c = segment[m_idx][1:0] + 2'($urandom_range(1, 3));
                press(4'b0001 << c);
            end else if (kind == 1) begin
                idle((j == 0) ? 0 : 1);
                do b = 4'($urandom_range(3, 15)); while ($countones(b) < 2);
                press(b);
            end else begin
                timeout_fail();
            end
            frozen(2);
        end

        // Two-round instance: win, restart from WIN, reset during round 1 playback.
        sel = 1'b1;
        mr  = 2;
        for (int i = 0; i < 32; i++) segment[i] = 3'($urandom_range(0, 7));
        do_reset();
        do_start();
        playback(4'b0000);
        play_round();
        playback(4'b0000);
        play_round();
        check_eq("win.flag", 32'(o_win), 32'd1);
        check_eq("win.score", 32'(o_sc), 32'd2);
        frozen(3);
        do_start();
        playback(4'b0000);
        play_round();
        tick();
        expect_now("r1_show", 1'b1, 1'b0);
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/simon_round_ctrl.md
# simon_round_ctrl

Round sequencer for the Simon Says game. It owns the round counter and walks the colour display through the stored 32-entry pattern for the current round. It then collects and checks the player's presses and decides whether the game advances, fails or is won. It drives the `check_round`/display-index inputs of `colourflash`, replacing the free-running stimulus used today.

## Interface
Parameters:
- FLASH_TICKS, 4, cycles each colour is lit during playback (≥1)
- GAP_TICKS, 2, blank cycles after each lit colour (≥1)
- TIMEOUT_TICKS, 64, cycles allowed between presses in INPUT before failure (≥2)
- MAX_ROUND, 32, number of rounds to win (≤32)

Ports:
- flash_clk  in  1  sole clock, all state on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begins a game; honoured only in IDLE, FAIL, WIN
- segment  in  32×3  colour pattern; only bits [1:0] of each entry are used (colour code 0–3)
- player_input  in  4  button levels, one-hot; bit c = colour code c
- check_round  out  5  index of last pattern entry in the current round (round length − 1)
- disp_idx  out  5  pattern entry currently shown / expected
- disp_on  out  1  colourflash lights segment[disp_idx]
- expect_input  out  1  high in INPUT
- game_over  out  1  high in FAIL
- win  out  1  high in WIN
- score  out  6  rounds completed this game

## Operation
- States: IDLE, SHOW_ON, SHOW_GAP, INPUT, FAIL, WIN.
- Reset or reset mid-game: IDLE. All outputs are 0: check_round=0, disp_idx=0, disp_on=0, expect_input=0, game_over=0, win=0, score=0. Timer=0, prev_input=0.
- IDLE/FAIL/WIN + start → SHOW_ON. check_round=0, disp_idx=0, score=0, timer=0. FAIL/WIN hold otherwise.
- start in any other state: ignored.
- SHOW_ON: disp_on=1 for FLASH_TICKS cycles → SHOW_GAP (disp_on=0) for GAP_TICKS cycles.
  - End of gap with disp_idx<check_round: disp_idx+1 → SHOW_ON.
  - Else → INPUT with disp_idx=0 and timer=0.
- Press: player_input≠0 this cycle and prev_input==0. prev_input is registered every cycle in every state.
  - A button held while entering INPUT is not a press until released and pressed again.
- Valid press: exactly one bit set, and its index equals segment[disp_idx][1:0]. A multi-hot press or a wrong colour is a mismatch.
- INPUT, valid press:
  - disp_idx<check_round: disp_idx+1, timer=0.
  - disp_idx==check_round: score+1. If check_round==MAX_ROUND−1 → WIN. Else check_round+1, disp_idx=0 → SHOW_ON.
- INPUT, mismatch → FAIL.
- INPUT, no press and timer reaches TIMEOUT_TICKS−1 → FAIL. A press in that same cycle wins over the timeout.
- FAIL/WIN: disp_idx and check_round are frozen so the failing or last entry stays visible. disp_on=0.

## Timing
- Registered outputs. Every decision takes effect on the edge that samples the triggering input, so it is visible 1 cycle after the input was applied.
- Playback of round r (check_round=r) lasts (r+1)·(FLASH_TICKS+GAP_TICKS) cycles from SHOW_ON entry to INPUT entry.
- The timer counts cycles in the current state. It is cleared on every state change and on every valid press in INPUT.
- score saturates at MAX_ROUND. check_round never exceeds MAX_ROUND−1. disp_idx never exceeds check_round.

## Structure
- Package simon_pkg:
  - state enum round_state_t
  - colour_t (2-bit)
  - MAX_ROUND_DEFAULT
  - one-hot-to-code function
- Sub-module press_detect:
  - prev_input register
  - press pulse
  - onehot_ok flag
  - 2-bit code
- The FSM and counters live in simon_round_ctrl.

## Test plan
Bench uses FLASH_TICKS=2, GAP_TICKS=1, TIMEOUT_TICKS=8, segment[i]=i%4.
- Reset, then pulse start → next cycle SHOW_ON, disp_on=1, disp_idx=0. Two cycles later disp_on=0. One cycle later expect_input=1.
- Round 0: press 4'b0001, release → check_round=1, score=1, SHOW_ON. Playback shows disp_idx 0,1 over 6 cycles, then INPUT.
- Round 1: press 4'b0001 then 4'b0100 (code 2, expected 1) → game_over=1, disp_idx=1, check_round=1. A following start restarts with score=0.
- INPUT with no press for 8 cycles → game_over=1. Separately, hold 4'b0001 through the INPUT transition → no advance until released and re-pressed. Press 4'b0011 → FAIL.
- Set MAX_ROUND=2 and play both rounds correctly → win=1, score=2. Assert reset during SHOW_ON of round 1 → all outputs 0 on the next cycle.
